// File: rtl/sbox_rand_supply_if.sv
// Seed/refresh bus between the cipher control, sbox_rand_supply and the masked S-box layer.
// The supply block takes the slave side; the controller/consumer takes the master side.
interface sbox_rand_supply_if #(
    parameter int RW = 72
);
    logic          seed_valid;
    logic [7:0]    seed_data;
    logic          seed_ready;
    logic          r_req;
    logic [RW-1:0] r;
    logic          r_valid;

    modport master (
        output seed_valid,
        output seed_data,
        output r_req,
        input  seed_ready,
        input  r,
        input  r_valid
    );

    modport slave (
        input  seed_valid,
        input  seed_data,
        input  r_req,
        output seed_ready,
        output r,
        output r_valid
    );
endinterface

// File: rtl/sbox_rand_supply.sv
// Fresh-randomness source for the three-share masked Midori S-box pair: byte-seeded 72-bit
// Fibonacci LFSR, warmed up, then advanced one word per consumed refresh. Optional HEALTH_CHECK_EN.
module sbox_rand_supply #(
    parameter int RW           = 72,
    parameter int STEPS        = 72,
    parameter int WARMUP_WORDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    sbox_rand_supply_if.slave   bus
`ifdef HEALTH_CHECK_EN
    ,
    output logic                alarm
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } fsm_e;

    localparam logic [3:0] LAST_BYTE = 4'd8;
    localparam logic [7:0] WARM_LAST = (WARMUP_WORDS == 0) ? 8'd0 : 8'(WARMUP_WORDS - 1);
    localparam logic [RW-1:0] ONE_WORD = {{(RW-1){1'b0}}, 1'b1};

    generate
        if (RW != 72) begin : g_bad_rw
            $error("sbox_rand_supply: RW must be 72");
        end
        if (STEPS < 1 || STEPS > 72) begin : g_bad_steps
            $error("sbox_rand_supply: STEPS must be 1..72");
        end
        if (WARMUP_WORDS < 0 || WARMUP_WORDS > 255) begin : g_bad_warm
            $error("sbox_rand_supply: WARMUP_WORDS must be 0..255");
        end
    endgenerate

    fsm_e          fsm_q, fsm_d;
    logic [RW-1:0] state_q, state_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    warm_cnt_q, warm_cnt_d;

    logic [RW-1:0] step_chain [0:STEPS];
    logic [RW-1:0] word_adv;
    logic [RW-1:0] seed_shift;
    logic          frozen;

    // Unrolled chain of single steps; taps 71/65/24/18 give the maximal-length polynomial.
    assign step_chain[0] = state_q;
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            assign step_chain[gi+1] = {step_chain[gi][RW-2:0],
                                       step_chain[gi][71] ^ step_chain[gi][65] ^
                                       step_chain[gi][24] ^ step_chain[gi][18]};
        end
    endgenerate

    assign word_adv   = step_chain[STEPS];
    assign seed_shift = {state_q[RW-9:0], bus.seed_data};

`ifdef HEALTH_CHECK_EN
    logic alarm_q, alarm_d;
    assign frozen = alarm_q;
    assign alarm  = alarm_q;
`else
    assign frozen = 1'b0;
`endif

    assign bus.r          = state_q;
    assign bus.r_valid    = (fsm_q == ST_RUN) && !frozen;
    assign bus.seed_ready = (fsm_q != ST_WARMUP) && !frozen;

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        warm_cnt_d = warm_cnt_q;
`ifdef HEALTH_CHECK_EN
        alarm_d    = alarm_q;
`endif
        if (!frozen) begin
            case (fsm_q)
                ST_LOAD: begin
                    if (bus.seed_valid) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            // An all-zero seed would lock the LFSR at zero forever.
                            state_d    = (seed_shift == '0) ? ONE_WORD : seed_shift;
                            byte_cnt_d = 4'd0;
                            fsm_d      = (WARMUP_WORDS == 0) ? ST_RUN : ST_WARMUP;
                        end else begin
                            state_d    = seed_shift;
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                end
                ST_WARMUP: begin
                    state_d = word_adv;
                    if (warm_cnt_q == WARM_LAST) begin
                        warm_cnt_d = 8'd0;
                        fsm_d      = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    // A reseed byte takes priority and becomes byte 1 of a fresh load.
                    if (bus.seed_valid) begin
                        state_d    = seed_shift;
                        byte_cnt_d = 4'd1;
                        fsm_d      = ST_LOAD;
                    end else if (bus.r_req) begin
`ifdef HEALTH_CHECK_EN
                        if (word_adv == state_q) begin
                            alarm_d = 1'b1;
                        end else begin
                            state_d = word_adv;
                        end
`else
                        state_d = word_adv;
`endif
                    end
                end
                default: begin
                    fsm_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_LOAD;
            state_q    <= '0;
            byte_cnt_q <= 4'd0;
            warm_cnt_q <= 8'd0;
`ifdef HEALTH_CHECK_EN
            alarm_q    <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            warm_cnt_q <= warm_cnt_d;
`ifdef HEALTH_CHECK_EN
            alarm_q    <= alarm_d;
`endif
        end
    end

endmodule
